// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared state encoding, funct3 encodings and size helpers for the byte-serial LSU.
package lsu_byte_sequencer_pkg;

  localparam int LSU_ADDR_W = 64;
  localparam int LSU_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B       = 3'b000;
  localparam logic [2:0] F3_H       = 3'b001;
  localparam logic [2:0] F3_W       = 3'b010;
  localparam logic [2:0] F3_D       = 3'b011;
  localparam logic [2:0] F3_BU      = 3'b100;
  localparam logic [2:0] F3_HU      = 3'b101;
  localparam logic [2:0] F3_WU      = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Index of the final byte of an access; doubles as the alignment mask.
  function automatic logic [2:0] last_index(input logic [1:0] size);
    logic [3:0] n;
    n = size_bytes(size) - 4'd1;
    return n[2:0];
  endfunction

  // Unsigned stores do not exist; 3'b111 is unused for both directions.
  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    return (funct3 == F3_ILLEGAL) || (write && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response port of the LSU and its byte-wide data-memory port.
interface lsu_byte_sequencer_if
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_byte_sequencer_mem_if
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr, mem_we, mem_re, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_we, mem_re, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Sign/zero extension of assembled little-endian load data according to funct3.
module lsu_byte_sequencer_load_extend
  import lsu_byte_sequencer_pkg::*;
(
  input  logic [63:0] asm_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  // Select width and extension; unknown encodings produce zero.
  always_comb begin
    data_o = 64'h0;
    case (funct3_i)
      F3_B:    data_o = {{56{asm_i[7]}}, asm_i[7:0]};
      F3_H:    data_o = {{48{asm_i[15]}}, asm_i[15:0]};
      F3_W:    data_o = {{32{asm_i[31]}}, asm_i[31:0]};
      F3_D:    data_o = asm_i;
      F3_BU:   data_o = {56'h0, asm_i[7:0]};
      F3_HU:   data_o = {48'h0, asm_i[15:0]};
      F3_WU:   data_o = {32'h0, asm_i[31:0]};
      default: data_o = 64'h0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: one request becomes 1-8 little-endian byte cycles.
// Optional build macro MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu_byte_sequencer
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
)
(
  input  logic                     clk,
  input  logic                     reset,
  lsu_byte_sequencer_if.slave      req_if,
  lsu_byte_sequencer_mem_if.master mem_if
);

  lsu_state_e        state_q;
  logic              ready_q;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        cnt_q;
  logic [2:0]        last_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_d;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [7:0]        mem_wdata_q;

  logic              accept_s;
  logic              misalign_s;
  logic              req_err_s;
  logic [2:0]        cnt_nxt_s;
  logic [DATA_W-1:0] ext_s;

  assign accept_s  = req_if.req_valid && ready_q;
  assign cnt_nxt_s = cnt_q + 3'd1;
  assign req_err_s = is_illegal(req_if.req_write, req_if.req_funct3) || misalign_s;

  // Misalignment trap: any address bit below the access size makes the request fail.
  always_comb begin
    misalign_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_s = |(req_if.req_addr[2:0] & last_index(req_if.req_funct3[1:0]));
`else
    misalign_s = 1'b0;
`endif
  end

  // Load data including the byte arriving this cycle, so the final byte reaches the response.
  always_comb begin
    asm_d = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = mem_if.mem_rdata;
  end

  lsu_byte_sequencer_load_extend u_load_extend (
    .asm_i    (asm_d),
    .funct3_i (f3_q),
    .data_o   (ext_s)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      write_q      <= 1'b0;
      f3_q         <= 3'b000;
      base_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      last_q       <= 3'd0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          mem_addr_q   <= '0;
          mem_we_q     <= 1'b0;
          mem_re_q     <= 1'b0;
          mem_wdata_q  <= 8'h00;
          if (accept_s) begin
            ready_q <= 1'b0;
            write_q <= req_if.req_write;
            f3_q    <= req_if.req_funct3;
            base_q  <= req_if.req_addr;
            wdata_q <= req_if.req_wdata;
            cnt_q   <= 3'd0;
            last_q  <= last_index(req_if.req_funct3[1:0]);
            asm_q   <= '0;
            if (req_err_s) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= XFER;
              mem_addr_q  <= req_if.req_addr;
              mem_we_q    <= req_if.req_write;
              mem_re_q    <= ~req_if.req_write;
              mem_wdata_q <= req_if.req_write ? req_if.req_wdata[7:0] : 8'h00;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        XFER: begin
          asm_q <= asm_d;
          if (cnt_q == last_q) begin
            state_q      <= DONE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= 8'h00;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? '0 : ext_s;
          end else begin
            cnt_q       <= cnt_nxt_s;
            mem_addr_q  <= base_q + {{(ADDR_W-3){1'b0}}, cnt_nxt_s};
            mem_wdata_q <= write_q ? wdata_q[{cnt_nxt_s, 3'b000} +: 8] : 8'h00;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          mem_addr_q   <= '0;
          mem_we_q     <= 1'b0;
          mem_re_q     <= 1'b0;
          mem_wdata_q  <= 8'h00;
        end
      endcase
    end
  end

  assign req_if.req_ready  = ready_q;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_err   = resp_err_q;
  assign req_if.resp_rdata = resp_rdata_q;
  assign mem_if.mem_addr   = mem_addr_q;
  assign mem_if.mem_we     = mem_we_q;
  assign mem_if.mem_re     = mem_re_q;
  assign mem_if.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench for lsu_byte_sequencer: vector table, scoreboard, reset/busy corner cases.
module tb_lsu_byte_sequencer;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[16];

  logic [7:0] mem [256];
  logic       mem_loaded = 1'b0;
  int         mem_cyc = 0;
  bit         both_seen = 1'b0;

  lsu_byte_sequencer_if     rif ();
  lsu_byte_sequencer_mem_if mif ();

  lsu_byte_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .req_if (rif),
    .mem_if (mif)
  );

  always #5 clk = ~clk;

  // Byte memory: byte[i]=i at start, combinational read, write at the rising edge.
  assign mif.mem_rdata = mem[mif.mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_loaded <= 1'b1;
    end else if (mif.mem_we) begin
      mem[mif.mem_addr[7:0]] <= mif.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clk) begin
    if (reset) begin
      mem_cyc   = 0;
      both_seen = 1'b0;
    end else begin
      if (mif.mem_re || mif.mem_we) mem_cyc++;
      if (mif.mem_re && mif.mem_we) both_seen = 1'b1;
      if (rif.resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_expected actual=unrequested response required=no response");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", rif.resp_rdata, e.rdata);
          check("resp_err", 64'(rif.resp_err), 64'(e.err));
          check("mem_cycles", 64'(mem_cyc), 64'(e.cyc));
          check("we_re_exclusive", 64'(both_seen), 64'd0);
        end
        mem_cyc   = 0;
        both_seen = 1'b0;
      end
    end
  end

  task automatic accept_only(input logic w, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] d);
    int waited = 0;
    @(negedge clk);
    while (!rif.req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rif.req_ready) check("ready_wait", 64'(rif.req_ready), 64'd1);
    rif.req_write  = w;
    rif.req_funct3 = f3;
    rif.req_addr   = a;
    rif.req_wdata  = d;
    rif.req_valid  = 1'b1;
    @(posedge clk);
    #1 rif.req_valid = 1'b0;
  endtask

  task automatic do_req(input vec_t v);
    int lat = 0;
    bit got = 1'b0;
    sb_q.push_back('{v.rdata, v.err, v.cyc});
    accept_only(v.write, v.f3, v.addr, v.wdata);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rif.resp_valid) got = 1'b1;
    end
    check("latency", got ? 64'(lat) : 64'hFFFF, 64'(v.cyc + 1));
    @(negedge clk);
    check("resp_one_cycle", 64'(rif.resp_valid), 64'd0);
  endtask

  initial begin
    rif.req_valid  = 1'b0;
    rif.req_write  = 1'b0;
    rif.req_funct3 = 3'b000;
    rif.req_addr   = 64'h0;
    rif.req_wdata  = 64'h0;
    reset = 1'b1;

    vecs[0]  = '{1'b0, 3'b011, 64'h8,  64'h0, 64'h0F0E0D0C0B0A0908, 1'b0, 8};
    vecs[1]  = '{1'b1, 3'b000, 64'h80, 64'h123456789ABCDEA5, 64'h0, 1'b0, 1};
    vecs[2]  = '{1'b0, 3'b000, 64'h80, 64'h0, 64'hFFFFFFFFFFFFFFA5, 1'b0, 1};
    vecs[3]  = '{1'b0, 3'b100, 64'h80, 64'h0, 64'h00000000000000A5, 1'b0, 1};
    vecs[4]  = '{1'b1, 3'b010, 64'h40, 64'hDEADBEEF80001234, 64'h0, 1'b0, 4};
    vecs[5]  = '{1'b0, 3'b010, 64'h40, 64'h0, 64'hFFFFFFFF80001234, 1'b0, 4};
    vecs[6]  = '{1'b0, 3'b110, 64'h40, 64'h0, 64'h0000000080001234, 1'b0, 4};
    vecs[7]  = '{1'b1, 3'b011, 64'h20, 64'h1122334455667788, 64'h0, 1'b0, 8};
    vecs[8]  = '{1'b0, 3'b011, 64'h20, 64'h0, 64'h1122334455667788, 1'b0, 8};
    vecs[9]  = '{1'b0, 3'b001, 64'hFE, 64'h0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 2};
    vecs[10] = '{1'b0, 3'b101, 64'hFE, 64'h0, 64'h000000000000FFFE, 1'b0, 2};
    vecs[11] = '{1'b0, 3'b111, 64'h20, 64'h0, 64'h0, 1'b1, 0};
    vecs[12] = '{1'b1, 3'b101, 64'h20, 64'hCAFECAFECAFECAFE, 64'h0, 1'b1, 0};
    vecs[13] = '{1'b0, 3'b011, 64'h20, 64'h0, 64'h1122334455667788, 1'b0, 8};
`ifdef MISALIGN_TRAP_EN
    vecs[14] = '{1'b0, 3'b001, 64'h3, 64'h0, 64'h0, 1'b1, 0};
    vecs[15] = '{1'b0, 3'b010, 64'hFFFFFFFFFFFFFFFE, 64'h0, 64'h0, 1'b1, 0};
`else
    vecs[14] = '{1'b0, 3'b001, 64'h3, 64'h0, 64'h0000000000000403, 1'b0, 2};
    vecs[15] = '{1'b0, 3'b010, 64'hFFFFFFFFFFFFFFFE, 64'h0, 64'h000000000100FFFE, 1'b0, 4};
`endif

    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({rif.resp_valid, rif.resp_err, mif.mem_we, mif.mem_re, rif.req_ready}),
          64'b00001);
    check("reset_rdata", rif.resp_rdata, 64'h0);
    check("reset_mem_addr", mif.mem_addr, 64'h0);
    check("reset_mem_wdata", 64'(mif.mem_wdata), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) do_req(vecs[i]);

    // Busy: a store presented during a load is neither accepted nor queued.
    sb_q.push_back('{64'h0000000000000005, 1'b0, 1});
    accept_only(1'b0, 3'b000, 64'h5, 64'h0);
    rif.req_write  = 1'b1;
    rif.req_funct3 = 3'b000;
    rif.req_addr   = 64'h5;
    rif.req_wdata  = 64'hEE;
    rif.req_valid  = 1'b1;
    @(negedge clk);
    check("busy_ready_xfer", 64'(rif.req_ready), 64'd0);
    @(negedge clk);
    check("busy_ready_done", 64'(rif.req_ready), 64'd0);
    rif.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_no_write", 64'(mem[5]), 64'h05);

    // Reset during an 8-byte store after three bytes have been committed.
    accept_only(1'b1, 3'b011, 64'h10, 64'h1122334455667788);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_we_low", 64'(mif.mem_we), 64'd0);
    check("abort_no_resp", 64'(rif.resp_valid), 64'd0);
    check("abort_ready", 64'(rif.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_bytes", {32'h0, mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 64'h13667788);
    do_req('{1'b0, 3'b011, 64'h10, 64'h0, 64'h1716151413667788, 1'b0, 8});

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
